// File: rtl/ramn_seq.sv
// ramn_seq: multi-read-port register-file RAM with registered reads and a
// sequential clear/preset sweep engine.
// Optional feature macro: RAMN_BYPASS_EN (write-first forwarding on read ports).
module ramn_seq #(
    parameter int unsigned           Width        = 8,
    parameter int unsigned           AddressWidth = 4,
    parameter int unsigned           ReadPorts    = 3,
    parameter logic [Width-1:0]      RST          = {Width{1'b0}},
    parameter logic [Width-1:0]      PST          = {Width{1'b1}}
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              clr,
    input  logic                              pst,
    input  logic                              we,
    input  logic [AddressWidth-1:0]           waddr,
    input  logic [Width-1:0]                  D,
    input  logic [ReadPorts*AddressWidth-1:0] raddr,
    output logic [ReadPorts*Width-1:0]        Q,
    output logic                              busy,
    output logic                              done
);

    localparam int unsigned DEPTH = 2 ** AddressWidth;
    localparam logic [AddressWidth-1:0] LAST = AddressWidth'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [AddressWidth-1:0] cnt;
    logic [AddressWidth-1:0] cnt_next;
    logic [Width-1:0]        fill;
    logic [Width-1:0]        fill_next;
    logic                    done_next;

    logic                    wr_en;
    logic [AddressWidth-1:0] wr_addr;
    logic [Width-1:0]        wr_data;

    logic [Width-1:0]        mem [DEPTH];
    logic [Width-1:0]        q_r [ReadPorts];
    logic [AddressWidth-1:0] ra  [ReadPorts];

    // Unpack read addresses and pack registered read data.
    for (genvar k = 0; k < ReadPorts; k++) begin : g_port
        assign ra[k]                 = raddr[k*AddressWidth +: AddressWidth];
        assign Q[k*Width +: Width]   = q_r[k];
    end

    // Sweep engine state, counter, fill value and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            fill  <= RST;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            fill  <= fill_next;
            busy  <= (state_next == SWEEP);
            done  <= done_next;
        end
    end

    // Next-state logic and write-port arbitration (sweep owns the port while active).
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        fill_next  = fill;
        done_next  = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = waddr;
        wr_data    = D;
        case (state)
            IDLE: begin
                wr_en = we;
                if (clr || pst) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                    fill_next  = clr ? RST : PST;
                end
            end
            SWEEP: begin
                wr_en    = 1'b1;
                wr_addr  = cnt;
                wr_data  = fill;
                cnt_next = cnt + AddressWidth'(1);
                if (cnt == LAST) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Storage array; reset fills every word with the reset pattern.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= RST;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read ports, one-cycle latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < int'(ReadPorts); k++) begin
                q_r[k] <= RST;
            end
        end else begin
            for (int k = 0; k < int'(ReadPorts); k++) begin
`ifdef RAMN_BYPASS_EN
                if (wr_en && (wr_addr == ra[k])) begin
                    q_r[k] <= wr_data;
                end else begin
                    q_r[k] <= mem[ra[k]];
                end
`else
                q_r[k] <= mem[ra[k]];
`endif
            end
        end
    end

endmodule

// File: tb/tb_ramn_seq.sv
// Self-checking bench for ramn_seq: directed scenarios plus random traffic
// checked against a behavioural memory model.
module tb_ramn_seq;

    localparam int unsigned W     = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned RP    = 3;
    localparam int          DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             pst;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [W-1:0]     d;
    logic [RP*AW-1:0] raddr;
    logic [RP*W-1:0]  q;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    ramn_seq #(
        .Width(W),
        .AddressWidth(AW),
        .ReadPorts(RP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .clr(clr),
        .pst(pst),
        .we(we),
        .waddr(waddr),
        .D(d),
        .raddr(raddr),
        .Q(q),
        .busy(busy),
        .done(done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: plain array plus "words left to sweep" bookkeeping.
    int mem_m [DEPTH];
    int sweep_left;
    int sweep_pos;
    int fill_m;
    int exp_q [RP];
    int exp_done;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 0;
        for (int k = 0; k < int'(RP); k++) exp_q[k] = 0;
        sweep_left = 0;
        sweep_pos  = 0;
        fill_m     = 0;
        exp_done   = 0;
    endtask

    task automatic check_outputs(input string where);
        for (int k = 0; k < int'(RP); k++)
            check($sformatf("%s q%0d", where, k), int'(q[k*W +: W]), exp_q[k]);
        check({where, " busy"}, int'(busy), (sweep_left > 0) ? 1 : 0);
        check({where, " done"}, int'(done), exp_done);
    endtask

    // One clock edge: update the model with the inputs seen at the edge, then compare.
    task automatic tick(input string where);
        bit wr_ok;
        int wr_a;
        int wr_v;
        int a;
        @(posedge clk);
        wr_ok = 0; wr_a = 0; wr_v = 0;
        if (sweep_left > 0) begin
            wr_ok = 1; wr_a = sweep_pos; wr_v = fill_m;
        end else if (we) begin
            wr_ok = 1; wr_a = int'(waddr); wr_v = int'(d);
        end
        for (int k = 0; k < int'(RP); k++) begin
            a = int'(raddr[k*AW +: AW]);
            exp_q[k] = mem_m[a];
`ifdef RAMN_BYPASS_EN
            if (wr_ok && wr_a == a) exp_q[k] = wr_v;
`endif
        end
        if (wr_ok) mem_m[wr_a] = wr_v;
        if (sweep_left > 0) begin
            sweep_pos  = (sweep_pos + 1) % DEPTH;
            sweep_left = sweep_left - 1;
            exp_done   = (sweep_left == 0) ? 1 : 0;
        end else begin
            exp_done = 0;
            if (clr || pst) begin
                sweep_left = DEPTH;
                sweep_pos  = 0;
                fill_m     = clr ? 0 : 255;
            end
        end
        #1;
        check_outputs(where);
    endtask

    task automatic apply_reset(input string where);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs(where);
        #2;
        rst = 1'b1;
    endtask

    task automatic set_raddr(input int a0, input int a1, input int a2);
        raddr = {AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic read_all(input string where);
        for (int a = 0; a < DEPTH; a++) begin
            set_raddr(a, (a + 5) % DEPTH, (a + 11) % DEPTH);
            tick(where);
        end
    endtask

    // Runs a sweep to completion within a bounded number of edges, measuring busy and done.
    task automatic run_sweep(input string where, input int inject_at, input bit inject_we);
        int busy_len;
        int done_cnt;
        int n;
        busy_len = int'(busy);
        done_cnt = 0;
        n = 0;
        while (n < 40) begin
            if (n == inject_at) begin
                if (inject_we) begin
                    we = 1'b1; waddr = AW'(2); d = 8'h11;
                end else begin
                    clr = 1'b1;
                end
            end else begin
                we = 1'b0; clr = 1'b0; pst = 1'b0;
            end
            tick(where);
            done_cnt += int'(done);
            n++;
            if (!busy) break;
            busy_len++;
        end
        we = 1'b0; clr = 1'b0; pst = 1'b0;
        check({where, " busy_len"}, busy_len, DEPTH);
        check({where, " done_cnt"}, done_cnt, 1);
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; pst = 1'b0; we = 1'b0;
        waddr = '0; d = '0; raddr = '0;
        #7;
        apply_reset("reset");

        // Reset then read
        set_raddr(5, 5, 5);
        tick("rd_after_reset");

        // Write then read, one-cycle latency
        we = 1'b1; waddr = AW'(3); d = 8'hA5;
        tick("write3");
        we = 1'b0;
        set_raddr(3, 4, 0);
        tick("read3");

        // Simultaneous write and read of the same address
        we = 1'b1; waddr = AW'(7); d = 8'h3C;
        set_raddr(0, 7, 7);
        tick("wr_rd_same");
        we = 1'b0;
        tick("rd7_after");

        // Preset sweep with a dropped mid-sweep write
        pst = 1'b1;
        tick("pst_req");
        pst = 1'b0;
        run_sweep("pst_sweep", 5, 1'b1);
        read_all("after_pst");

        // clr and pst together; clr during sweep ignored
        clr = 1'b1; pst = 1'b1;
        tick("clrpst_req");
        clr = 1'b0; pst = 1'b0;
        run_sweep("clr_sweep", 4, 1'b0);
        read_all("after_clr");

        // Reset mid-sweep
        we = 1'b1; waddr = AW'(9); d = 8'h5A;
        tick("pre_sweep_write");
        we = 1'b0;
        pst = 1'b1;
        tick("pst_req2");
        pst = 1'b0;
        for (int i = 0; i < 6; i++) tick("mid_sweep");
        apply_reset("reset_mid_sweep");
        read_all("after_mid_reset");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = AW'($urandom_range(0, DEPTH - 1));
            d     = W'($urandom);
            raddr = RP*AW'($urandom);
            clr   = ($urandom_range(0, 59) == 0);
            pst   = ($urandom_range(0, 49) == 0);
            tick("random");
        end
        we = 1'b0; clr = 1'b0; pst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ramn_seq.md
Name: ramn_seq

Overview:
- Parametrised multi-read-port register-file RAM; successor to the three-read-port combinational word array.
- Adds a configurable read-port count, registered reads, and a sequential sweep engine that fills every word with the reset or preset pattern at run time.
- Sits in the memory library as the general storage primitive for register files and lookup buffers.

Parameters:
Width, 8, data word width in bits
AddressWidth, 4, address width; Depth = 2**AddressWidth words
ReadPorts, 3, number of independent read ports (>=1)
RST, {Width{1'b0}}, value loaded on reset and by a clear sweep
PST, {Width{1'b1}}, value loaded by a preset sweep

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
clr  input  1  request a clear sweep (fill all words with RST)
pst  input  1  request a preset sweep (fill all words with PST)
we  input  1  write enable
waddr  input  AddressWidth  write address
D  input  Width  write data
raddr  input  ReadPorts*AddressWidth  packed read addresses; port k uses bits [k*AddressWidth +: AddressWidth]
Q  output  ReadPorts*Width  packed registered read data; port k uses bits [k*Width +: Width]
busy  output  1  high while a sweep is in progress
done  output  1  one-cycle pulse on the cycle after the final sweep write

Behaviour:
- Reset (rst=0, asynchronous):
  - All Depth words = RST, every Q slice = RST.
  - State IDLE, sweep counter = 0, busy = 0, done = 0.
  - Takes effect immediately, including mid-sweep; the sweep is abandoned.
- States IDLE and SWEEP.
- IDLE:
  - If clr=1 or pst=1 at an edge, go to SWEEP with counter = 0 and fill value latched: RST if clr=1, else PST. clr wins if both are high.
  - busy rises on that same edge.
  - A we on the same edge as the request is still performed.
  - Otherwise, if we=1, mem[waddr] <= D.
- SWEEP:
  - Each edge writes the fill value to mem[counter], then counter <= counter+1.
  - When counter == Depth-1, the last word is written, state goes to IDLE, busy falls and done = 1 for exactly one cycle.
  - Total sweep = Depth edges, from the first edge with busy high to busy low.
  - we, clr and pst are ignored (dropped, not queued) while busy=1.
  - The counter wraps naturally at AddressWidth bits; no wider arithmetic.
- Reads:
  - Every edge, for each port k, Q_k <= mem[raddr_k], with 1-cycle latency.
  - Reads see the contents before that edge's write (read-old-data) unless RAMN_BYPASS_EN is defined.
  - Reads proceed normally during a sweep.
  - Several ports may address the same word; each gets identical data.
- The write port plus one sweep write can never occur on the same edge; the sweep has exclusive write access.
- done is 0 in all cycles except the one after sweep completion.

Optional Feature:
- Macro: RAMN_BYPASS_EN.
- Defined: write-first forwarding on each read port.
  - If a write is performed on an edge and its address equals raddr_k, Q_k <= D.
  - For a sweep write, Q_k <= the fill value.
  - Latency stays 1 cycle.
- Undefined: read-old-data as described above, with no comparator logic.

Test Plan:
- Reset then read: rst=0→1, raddr all ports = 5 → Q slices = 8'h00 one cycle later; busy=0, done=0.
- Write/read latency: we=1, waddr=3, D=8'hA5; next cycle raddr0=3 → Q0=8'hA5 one edge later; port1 at addr 4 → 8'h00.
- Simultaneous write/read of same address, waddr=raddr1=7, D=8'h3C:
  - Q1 = old value 8'h00 without RAMN_BYPASS_EN.
  - Q1 = 8'h3C with it.
- Preset sweep:
  - pst pulse → busy high for 16 cycles, done pulses once.
  - All 16 addresses read 8'hFF afterwards.
  - we=1, waddr=2, D=8'h11 issued mid-sweep is dropped; addr2 reads 8'hFF.
- clr and pst both high in IDLE → sweep fills 8'h00; a clr pulse during the sweep is ignored; busy length is still 16.
- Reset mid-sweep: pst sweep, assert rst=0 at counter=6 → busy=0 immediately, all words 8'h00, no done pulse.
